// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encodings and default width for the shared-ALU arbiter.
package alu_pkg;
  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_CMP = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU producing the exact response values (data and flags) the
// arbiter captures; CMP and illegal opcodes are resolved here.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] data,
  output logic              zero,
  output logic              carry,
  output logic              err
);
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] logic_res;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    logic_res = '0;
    data      = '0;
    zero      = 1'b0;
    carry     = 1'b0;
    err       = 1'b0;
    case (op)
      OP_ADD: begin
        {carry, data} = sum;
        zero          = (sum[DATA_W-1:0] == '0);
      end
      OP_SUB: begin
        {carry, data} = diff;
        zero          = (diff[DATA_W-1:0] == '0);
      end
      OP_CMP: begin
        zero  = (a == b);
        carry = (a < b);
      end
      OP_AND, OP_OR, OP_XOR: begin
        logic_res = (op == OP_AND) ? (a & b) : (op == OP_OR) ? (a | b) : (a ^ b);
        data      = logic_res;
        zero      = (logic_res == '0);
      end
      // 6/7: flag the error, everything else stays zero
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters;
// operands are held for EXEC_CYCLES, then the result is held until accepted.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic              resp_carry,
  output logic              resp_err,
  output logic              busy
);
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              id_q, id_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rzero_q, rzero_d, rcarry_q, rcarry_d, rerr_q, rerr_d;

  logic              gnt_any, gnt_id;
  logic [DATA_W-1:0] alu_data;
  logic              alu_zero, alu_carry, alu_err;

  alu_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
    .op(op_q), .a(a_q), .b(b_q),
    .data(alu_data), .zero(alu_zero), .carry(alu_carry), .err(alu_err)
  );

  // Pointer only matters on a tie; a lone valid always wins.
  assign gnt_any = req0_valid | req1_valid;
  assign gnt_id  = (req0_valid && req1_valid) ? rr_q : req1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      id_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rdata_q  <= '0;
      rzero_q  <= 1'b0;
      rcarry_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rdata_q  <= rdata_d;
      rzero_q  <= rzero_d;
      rcarry_q <= rcarry_d;
      rerr_q   <= rerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rdata_d  = rdata_q;
    rzero_d  = rzero_q;
    rcarry_d = rcarry_q;
    rerr_d   = rerr_q;
    case (state_q)
      ST_IDLE: if (gnt_any) begin
        op_d    = gnt_id ? req1_op : req0_op;
        a_d     = gnt_id ? req1_a  : req0_a;
        b_d     = gnt_id ? req1_b  : req0_b;
        id_d    = gnt_id;
        rr_d    = ~gnt_id;
        cnt_d   = CNT_INIT;
        state_d = ST_EXEC;
      end
      ST_EXEC: if (cnt_q != '0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        rdata_d  = alu_data;
        rzero_d  = alu_zero;
        rcarry_d = alu_carry;
        rerr_d   = alu_err;
        state_d  = ST_RESP;
      end
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = rst_n && (state_q == ST_IDLE) && req0_valid && !gnt_id;
    req1_ready = rst_n && (state_q == ST_IDLE) && req1_valid && gnt_id;
    resp_valid = (state_q == ST_RESP);
    busy       = (state_q != ST_IDLE);
    resp_id    = id_q;
    resp_data  = rdata_q;
    resp_zero  = rzero_q;
    resp_carry = rcarry_q;
    resp_err   = rerr_q;
  end
endmodule
